// File: rtl/regfile_scoreboard.sv
// Scoreboarded register file: per-entry in-flight bit, producer group and one
// value per commit bank. Reads return the bank owned by the entry's producer
// group with one cycle of latency. A clear walk zeroes the array after reset
// or on request before the file becomes operational.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (same-cycle commit bypass
// onto the read ports).
module regfile_scoreboard #(
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int GW = (WRITE_PORTS > 1) ? $clog2(WRITE_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_clear,
  output logic                             init_done,
  input  logic                             alloc_valid,
  input  logic [AW-1:0]                    alloc_addr,
  input  logic [GW-1:0]                    alloc_group,
  input  logic                             flush,
  input  logic [WRITE_PORTS-1:0]           commit_valid,
  input  logic [WRITE_PORTS*AW-1:0]        commit_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] commit_data,
  input  logic                             wb_suppress,
  input  logic [READ_PORTS-1:0]            rd_valid,
  input  logic [READ_PORTS*AW-1:0]         rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]            rd_ready
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic            r_init_done;
  logic            w_run;
  logic            w_alloc_eff;

  logic [AW-1:0]         w_cm_addr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0] w_cm_data [WRITE_PORTS];
  logic                  w_cm_eff  [WRITE_PORTS];

  // Array state; only the clear walk initialises these.
  logic                  r_inflight [DEPTH];
  logic [GW-1:0]         r_group    [DEPTH];
  logic [DATA_WIDTH-1:0] r_bank     [WRITE_PORTS][DEPTH];

  assign w_run       = (r_state == S_RUN);
  assign init_done   = r_init_done;
  assign w_alloc_eff = alloc_valid & ~flush & (alloc_addr != '0) & w_run;

  // Unpack commit ports and qualify each one.
  always_comb begin
    for (int i = 0; i < WRITE_PORTS; i++) begin
      w_cm_addr[i] = commit_addr[i*AW +: AW];
      w_cm_data[i] = commit_data[i*DATA_WIDTH +: DATA_WIDTH];
      w_cm_eff[i]  = commit_valid[i] & ~wb_suppress & (w_cm_addr[i] != '0) & w_run;
    end
  end

  // Control state, walk index and init_done register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_init_done <= (w_state_next == S_RUN);
    end
  end

  // Next-state: walk one entry per cycle, restart whenever init_clear is seen.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_CLEAR: begin
        if (init_clear) begin
          w_idx_next = '0;
        end else if (r_idx == AW'(DEPTH - 1)) begin
          w_state_next = S_RUN;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      S_RUN: begin
        if (init_clear) begin
          w_state_next = S_CLEAR;
          w_idx_next   = '0;
        end
      end
      default: begin
        w_state_next = S_CLEAR;
        w_idx_next   = '0;
      end
    endcase
  end

  // Scoreboard metadata: commits from the owning group retire, a same-cycle
  // alloc overrides the retire because its assignment comes last.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_inflight[r_idx] <= 1'b0;
      r_group[r_idx]    <= '0;
    end else begin
      for (int i = 0; i < WRITE_PORTS; i++) begin
        if (w_cm_eff[i] && (r_group[w_cm_addr[i]] == GW'(i))) begin
          r_inflight[w_cm_addr[i]] <= 1'b0;
        end
      end
      if (w_alloc_eff) begin
        r_inflight[alloc_addr] <= 1'b1;
        r_group[alloc_addr]    <= alloc_group;
      end
    end
  end

  // Data banks: each commit port owns one bank, written regardless of group.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WRITE_PORTS; b++) begin
      if (!w_run) begin
        r_bank[b][r_idx] <= '0;
      end else if (w_cm_eff[b]) begin
        r_bank[b][w_cm_addr[b]] <= w_cm_data[b];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [AW-1:0]         w_ra;
      logic [GW-1:0]         w_rg;
      logic                  w_rdy_next;
      logic [DATA_WIDTH-1:0] w_dat_next;
      logic                  r_rdy;
      logic [DATA_WIDTH-1:0] r_dat;

      assign w_ra = rd_addr[gi*AW +: AW];
      assign w_rg = r_group[w_ra];

      // Operand lookup: bank chosen by stored group, ready from pre-update inflight.
      always_comb begin
        w_rdy_next = 1'b1;
        w_dat_next = '0;
        if (w_ra != '0) begin
          w_rdy_next = ~r_inflight[w_ra];
          for (int b = 0; b < WRITE_PORTS; b++) begin
            if (w_rg == GW'(b)) begin
              w_dat_next = r_bank[b][w_ra];
            end
          end
`ifdef REGFILE_WRITE_BYPASS_EN
          for (int b = 0; b < WRITE_PORTS; b++) begin
            if (w_cm_eff[b] && (w_cm_addr[b] == w_ra) && (w_rg == GW'(b))) begin
              w_rdy_next = 1'b1;
              w_dat_next = w_cm_data[b];
            end
          end
`else
          // Same-cycle producer commits are not forwarded; the reader sees
          // not-ready and re-reads once the bank holds the new value.
`endif
        end
      end

      // Read output register: zero while clearing, hold when no request.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_rdy <= 1'b0;
          r_dat <= '0;
        end else if (!w_run) begin
          r_rdy <= 1'b0;
          r_dat <= '0;
        end else if (rd_valid[gi]) begin
          r_rdy <= w_rdy_next;
          r_dat <= w_dat_next;
        end
      end

      assign rd_ready[gi]                          = r_rdy;
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_dat;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: read expectations are queued when
// a read is driven and compared one cycle later when the registered result appears.
module tb_regfile_scoreboard;
  localparam int WP = 2;
  localparam int RP = 2;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int GW = 1;

  logic               clk;
  logic               rst;
  logic               init_clear;
  logic               init_done;
  logic               alloc_valid;
  logic [AW-1:0]      alloc_addr;
  logic [GW-1:0]      alloc_group;
  logic               flush;
  logic [WP-1:0]      commit_valid;
  logic [WP*AW-1:0]   commit_addr;
  logic [WP*DW-1:0]   commit_data;
  logic               wb_suppress;
  logic [RP-1:0]      rd_valid;
  logic [RP*AW-1:0]   rd_addr;
  logic [RP*DW-1:0]   rd_data;
  logic [RP-1:0]      rd_ready;

  int n_tests;
  int n_fail;
  int n_txn;

  typedef struct {
    int          port;
    logic        rdy;
    logic [31:0] data;
  } exp_t;
  exp_t q_exp[$];

  regfile_scoreboard #(
    .WRITE_PORTS(WP), .READ_PORTS(RP), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .init_clear(init_clear), .init_done(init_done),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_group(alloc_group),
    .flush(flush), .commit_valid(commit_valid), .commit_addr(commit_addr),
    .commit_data(commit_data), .wb_suppress(wb_suppress), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    init_clear   = 1'b0;
    alloc_valid  = 1'b0;
    alloc_addr   = '0;
    alloc_group  = '0;
    flush        = 1'b0;
    commit_valid = '0;
    commit_addr  = '0;
    commit_data  = '0;
    wb_suppress  = 1'b0;
    rd_valid     = '0;
    rd_addr      = '0;
  endtask

  task automatic alloc(input int a, input int g);
    alloc_valid = 1'b1;
    alloc_addr  = AW'(a);
    alloc_group = GW'(g);
  endtask

  task automatic commit(input int p, input int a, input logic [31:0] d);
    commit_valid[p]           = 1'b1;
    commit_addr[p*AW +: AW]   = AW'(a);
    commit_data[p*DW +: DW]   = d;
  endtask

  // Drive a read and queue what it must return next cycle.
  task automatic rd(input int p, input int a, input logic r, input logic [31:0] d);
    exp_t e;
    rd_valid[p]           = 1'b1;
    rd_addr[p*AW +: AW]   = AW'(a);
    e.port = p; e.rdy = r; e.data = d;
    q_exp.push_back(e);
  endtask

  // Queue an expectation for a port that is not reading (output must hold).
  task automatic hold(input int p, input logic r, input logic [31:0] d);
    exp_t e;
    e.port = p; e.rdy = r; e.data = d;
    q_exp.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      n_txn++;
      $display("[TB] txn %0d port %0d ready=%0b data=0x%08h (exp %0b 0x%08h)",
               n_txn, e.port, rd_ready[e.port], rd_data[e.port*DW +: DW], e.rdy, e.data);
      chk($sformatf("txn%0d_p%0d_ready", n_txn, e.port), 64'(rd_ready[e.port]), 64'(e.rdy));
      chk($sformatf("txn%0d_p%0d_data", n_txn, e.port), 64'(rd_data[e.port*DW +: DW]), 64'(e.data));
    end
    idle();
  endtask

  // Count cycles until init_done, bounded.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'd64);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_txn   = 0;
    rst     = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);

    // Walk after release, then clean reads.
    rst = 1'b1;
    wait_done("init_latency");
    rd(0, 9, 1'b1, 32'h0);
    rd(1, 0, 1'b1, 32'h0);
    tick();

    // Alloc with group 1; wrong-port commit does not retire it.
    alloc(5, 1); tick();
    rd(0, 5, 1'b0, 32'h0); tick();
    commit(0, 5, 32'h1); tick();
    rd(0, 5, 1'b0, 32'h0); tick();
    commit(1, 5, 32'hDEADBEEF); tick();
    rd(0, 5, 1'b1, 32'hDEADBEEF); tick();

    // Read in the same cycle as the producing commit.
    alloc(5, 1); tick();
    commit(1, 5, 32'hCAFEF00D);
`ifdef REGFILE_WRITE_BYPASS_EN
    rd(0, 5, 1'b1, 32'hCAFEF00D);
`else
    rd(0, 5, 1'b0, 32'hDEADBEEF);
`endif
    tick();
    rd(0, 5, 1'b1, 32'hCAFEF00D); tick();

    // Alloc and commit to the same entry in one cycle: stays in flight.
    alloc(7, 0); commit(0, 7, 32'h55); tick();
    rd(1, 7, 1'b0, 32'h55); tick();
    commit(0, 7, 32'h66); tick();
    rd(1, 7, 1'b1, 32'h66); tick();
    hold(1, 1'b1, 32'h66); tick();

    // Suppressed writeback and flushed alloc.
    alloc(3, 0); tick();
    wb_suppress = 1'b1; commit(0, 3, 32'h77); tick();
    rd(0, 3, 1'b0, 32'h0); tick();
    flush = 1'b1; alloc(4, 1); tick();
    rd(0, 4, 1'b1, 32'h0); tick();
    commit(0, 3, 32'h77); tick();
    rd(0, 3, 1'b1, 32'h77); tick();

    // Two commits to one entry in one cycle, read on both ports.
    alloc(10, 0); tick();
    alloc(11, 1); tick();
    commit(0, 10, 32'hA0); commit(1, 10, 32'hB0); tick();
    commit(0, 11, 32'hA1); commit(1, 11, 32'hB1); tick();
    rd(0, 10, 1'b1, 32'hA0);
    rd(1, 11, 1'b1, 32'hB1);
    tick();

    // Address 0 is never allocated or written.
    alloc(0, 1); commit(1, 0, 32'h99); tick();
    rd(0, 0, 1'b1, 32'h0); tick();

    // Reset mid-walk restarts the walk from index 0.
    rst = 1'b0;
    #1;
    chk("rst2_init_done", 64'(init_done), 64'd0);
    chk("rst2_rd_ready", 64'(rd_ready), 64'd0);
    tick();
    rst = 1'b1;
    repeat (30) tick();
    rst = 1'b0;
    #1;
    chk("midwalk_init_done", 64'(init_done), 64'd0);
    tick();
    rst = 1'b1;
    wait_done("rewalk_latency");
    rd(0, 5, 1'b1, 32'h0);
    rd(1, 10, 1'b1, 32'h0);
    tick();

    // init_clear from RUN (re-issued mid-walk) clears all data.
    alloc(12, 1); tick();
    commit(1, 12, 32'h1234); tick();
    rd(0, 12, 1'b1, 32'h1234); tick();
    init_clear = 1'b1; tick();
    chk("clear_init_done", 64'(init_done), 64'd0);
    rd(0, 12, 1'b0, 32'h0);
    repeat (10) tick();
    init_clear = 1'b1; tick();
    wait_done("clear_latency");
    rd(0, 12, 1'b1, 32'h0);
    rd(1, 7, 1'b1, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
